// File: rtl/decode_stage.sv
// decode_stage: RV32/RV64 instruction decode with a main + skid output buffer.
// Decoded fields are computed from in_inst on accept and held in registers.

`ifndef TYPE_R
`define TYPE_R 3'd0
`define TYPE_I 3'd1
`define TYPE_S 3'd2
`define TYPE_B 3'd3
`define TYPE_U 3'd4
`define TYPE_J 3'd5
`endif

module decode_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_inst,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [6:0]         out_opcode,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rs,
   output logic [4:0]         out_rs2,
   output logic [2:0]         out_funct3,
   output logic [6:0]         out_funct7,
   output logic [XLEN-1:0]    out_imm,
   output logic [SHAMT_W-1:0] out_shamt,
   output logic [2:0]         out_opcode_type,
   output logic               out_is_r_type,
   output logic               out_is_load,
   output logic               out_is_store,
   output logic               out_is_writeback,
   output logic               out_use_adder,
   output logic               out_illegal
);

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [6:0]         opcode;
      logic [4:0]         rd;
      logic [4:0]         rs;
      logic [4:0]         rs2;
      logic [2:0]         funct3;
      logic [6:0]         funct7;
      logic [XLEN-1:0]    imm;
      logic [SHAMT_W-1:0] shamt;
      logic [2:0]         otype;
      logic               is_r_type;
      logic               is_load;
      logic               is_store;
      logic               is_writeback;
      logic               use_adder;
      logic               illegal;
   } dec_t;

   dec_t r_main, r_skid;
   logic r_main_valid, r_skid_valid, r_in_ready;

   dec_t w_dec, w_main_nxt, w_skid_nxt;
   logic w_main_valid_nxt, w_skid_valid_nxt, w_in_ready_nxt;
   logic w_accept, w_main_fire;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

   // Sign-extended immediates for each encoding format
   assign w_imm_i = XLEN'($signed(in_inst[31:20]));
   assign w_imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
   assign w_imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
   assign w_imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
   assign w_imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

   // Decode the incoming instruction word into the buffered payload
   always_comb begin
      w_dec        = '0;
      w_dec.pc     = in_pc;
      w_dec.opcode = in_inst[6:0];
      w_dec.rd     = in_inst[11:7];
      w_dec.funct3 = in_inst[14:12];
      w_dec.rs     = in_inst[19:15];
      w_dec.rs2    = in_inst[24:20];
      w_dec.funct7 = in_inst[31:25];
      w_dec.shamt  = in_inst[20 +: SHAMT_W];
      w_dec.otype  = `TYPE_I;
      case (in_inst[6:0])
         OPC_LUI, OPC_AUIPC: begin
            w_dec.is_writeback = 1'b1;
            w_dec.otype        = `TYPE_U;
            w_dec.imm          = w_imm_u;
         end
         OPC_OP: begin
            w_dec.is_writeback = 1'b1;
            w_dec.otype        = `TYPE_R;
         end
         OPC_OP_IMM: begin
            w_dec.is_writeback = 1'b1;
            w_dec.imm          = w_imm_i;
         end
         OPC_JAL: begin
            w_dec.is_writeback = 1'b1;
            w_dec.use_adder    = 1'b1;
            w_dec.otype        = `TYPE_J;
            w_dec.imm          = w_imm_j;
         end
         OPC_JALR: begin
            w_dec.is_writeback = 1'b1;
            w_dec.use_adder    = 1'b1;
            w_dec.imm          = w_imm_i;
         end
         OPC_BRANCH: begin
            w_dec.use_adder = 1'b1;
            w_dec.otype     = `TYPE_B;
            w_dec.imm       = w_imm_b;
         end
         OPC_LOAD: begin
            w_dec.is_load      = 1'b1;
            w_dec.is_writeback = 1'b1;
            w_dec.use_adder    = 1'b1;
            w_dec.imm          = w_imm_i;
         end
         OPC_STORE: begin
            w_dec.is_store  = 1'b1;
            w_dec.use_adder = 1'b1;
            w_dec.otype     = `TYPE_S;
            w_dec.imm       = w_imm_s;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            w_dec.imm = w_imm_i;
         end
         OPC_OP_IMM_32: begin
            if (XLEN == 64) begin
               w_dec.is_writeback = 1'b1;
               w_dec.imm          = w_imm_i;
            end else begin
               w_dec.illegal = 1'b1;
            end
         end
         OPC_OP_32: begin
            if (XLEN == 64) begin
               w_dec.is_writeback = 1'b1;
               w_dec.otype        = `TYPE_R;
            end else begin
               w_dec.illegal = 1'b1;
            end
         end
         default: w_dec.illegal = 1'b1;
      endcase
      w_dec.is_r_type = (w_dec.otype == `TYPE_R);
   end

   assign w_accept    = in_valid & r_in_ready;
   assign w_main_fire = r_main_valid & out_ready;

   // Main/skid next-state: flush wins, then skid->main move, then accept
   always_comb begin
      w_main_nxt       = r_main;
      w_skid_nxt       = r_skid;
      w_main_valid_nxt = r_main_valid;
      w_skid_valid_nxt = r_skid_valid;
      if (flush) begin
         w_main_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else if (w_main_fire && r_skid_valid) begin
         w_main_nxt       = r_skid;
         w_skid_valid_nxt = 1'b0;
      end else if (w_accept && (!r_main_valid || w_main_fire)) begin
         w_main_nxt       = w_dec;
         w_main_valid_nxt = 1'b1;
      end else if (w_accept) begin
         w_skid_nxt       = w_dec;
         w_skid_valid_nxt = 1'b1;
      end else if (w_main_fire) begin
         w_main_valid_nxt = 1'b0;
      end
      w_in_ready_nxt = ~w_skid_valid_nxt;
   end

   // Buffer registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b0;
      end else begin
         r_main       <= w_main_nxt;
         r_skid       <= w_skid_nxt;
         r_main_valid <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= w_in_ready_nxt;
      end
   end

   assign in_ready         = r_in_ready;
   assign out_valid        = r_main_valid;
   assign out_pc           = r_main.pc;
   assign out_opcode       = r_main.opcode;
   assign out_rd           = r_main.rd;
   assign out_rs           = r_main.rs;
   assign out_rs2          = r_main.rs2;
   assign out_funct3       = r_main.funct3;
   assign out_funct7       = r_main.funct7;
   assign out_imm          = r_main.imm;
   assign out_shamt        = r_main.shamt;
   assign out_opcode_type  = r_main.otype;
   assign out_is_r_type    = r_main.is_r_type;
   assign out_is_load      = r_main.is_load;
   assign out_is_store     = r_main.is_store;
   assign out_is_writeback = r_main.is_writeback;
   assign out_use_adder    = r_main.use_adder;
   assign out_illegal      = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage at XLEN=32 and XLEN=64.

`ifndef TYPE_R
`define TYPE_R 3'd0
`define TYPE_I 3'd1
`define TYPE_S 3'd2
`define TYPE_B 3'd3
`define TYPE_U 3'd4
`define TYPE_J 3'd5
`endif

module tb_decode_stage;

   // flg = {is_r_type, is_load, is_store, is_writeback, use_adder, illegal}
   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [5:0]  shamt;
      logic [2:0]  typ;
      logic [5:0]  flg;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst, in_pc, out_pc, out_imm;
   logic [6:0]  out_opcode, out_funct7;
   logic [4:0]  out_rd, out_rs, out_rs2, out_shamt;
   logic [2:0]  out_funct3, out_opcode_type;
   logic out_is_r_type, out_is_load, out_is_store, out_is_writeback, out_use_adder, out_illegal;

   logic b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [31:0] b_in_inst;
   logic [63:0] b_in_pc, b_out_pc, b_out_imm;
   logic [6:0]  b_out_opcode, b_out_funct7;
   logic [4:0]  b_out_rd, b_out_rs, b_out_rs2;
   logic [5:0]  b_out_shamt;
   logic [2:0]  b_out_funct3, b_out_opcode_type;
   logic b_out_is_r_type, b_out_is_load, b_out_is_store, b_out_is_writeback, b_out_use_adder, b_out_illegal;

   decode_stage #(.XLEN(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs),
      .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
      .out_shamt(out_shamt), .out_opcode_type(out_opcode_type), .out_is_r_type(out_is_r_type),
      .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_writeback(out_is_writeback),
      .out_use_adder(out_use_adder), .out_illegal(out_illegal));

   decode_stage #(.XLEN(64)) u64 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
      .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_pc(b_out_pc), .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs(b_out_rs),
      .out_rs2(b_out_rs2), .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
      .out_shamt(b_out_shamt), .out_opcode_type(b_out_opcode_type), .out_is_r_type(b_out_is_r_type),
      .out_is_load(b_out_is_load), .out_is_store(b_out_is_store), .out_is_writeback(b_out_is_writeback),
      .out_use_adder(b_out_use_adder), .out_illegal(b_out_illegal));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t q32[$];
   exp_t q64[$];

   always @(posedge clk) cyc++;

   function automatic exp_t mk(input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] imm, input logic [5:0] sh,
                               input logic [2:0] typ, input logic [5:0] flg);
      exp_t e;
      e.inst = inst; e.pc = pc; e.imm = imm; e.shamt = sh; e.typ = typ; e.flg = flg;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, req);
      end
   endtask

   // Monitor for the 32-bit instance: pop on every output transfer
   always @(negedge clk) begin
      exp_t e, a;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (q32.size() == 0) begin
            failures++;
            $display("FAIL sb32_unexpected got_pc=%h exp=none", out_pc);
         end else begin
            e = q32.pop_front();
            a.inst  = {out_funct7, out_rs2, out_rs, out_funct3, out_rd, out_opcode};
            a.pc    = 64'(out_pc);
            a.imm   = 64'(out_imm);
            a.shamt = 6'(out_shamt);
            a.typ   = out_opcode_type;
            a.flg   = {out_is_r_type, out_is_load, out_is_store, out_is_writeback, out_use_adder, out_illegal};
            if (a !== e) begin
               failures++;
               $display("FAIL sb32 got=%h exp=%h", a, e);
            end
         end
      end
   end

   // Monitor for the 64-bit instance
   always @(negedge clk) begin
      exp_t e, a;
      if (!rst && b_out_valid && b_out_ready) begin
         checks++;
         if (q64.size() == 0) begin
            failures++;
            $display("FAIL sb64_unexpected got_pc=%h exp=none", b_out_pc);
         end else begin
            e = q64.pop_front();
            a.inst  = {b_out_funct7, b_out_rs2, b_out_rs, b_out_funct3, b_out_rd, b_out_opcode};
            a.pc    = b_out_pc;
            a.imm   = b_out_imm;
            a.shamt = b_out_shamt;
            a.typ   = b_out_opcode_type;
            a.flg   = {b_out_is_r_type, b_out_is_load, b_out_is_store, b_out_is_writeback, b_out_use_adder, b_out_illegal};
            if (a !== e) begin
               failures++;
               $display("FAIL sb64 got=%h exp=%h", a, e);
            end
         end
      end
   end

   // Offer one instruction; expectation is queued in the cycle it is accepted
   task automatic send(input bit wide, input exp_t e);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      if (wide) begin
         b_in_valid = 1'b1; b_in_inst = e.inst; b_in_pc = e.pc;
      end else begin
         in_valid = 1'b1; in_inst = e.inst; in_pc = e.pc[31:0];
      end
      while (!ok && n < 40) begin
         @(negedge clk);
         if (wide ? b_in_ready : in_ready) begin
            ok = 1'b1;
            if (wide) q64.push_back(e);
            else q32.push_back(e);
         end
         @(posedge clk); #1;
         n++;
      end
      if (wide) b_in_valid = 1'b0;
      else in_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got=no_accept exp=accept inst=%h", e.inst);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   exp_t v32[16];
   exp_t v64[6];

   initial begin
      int c0;
      exp_t xa, xb, xc, xx;

      v32[0]  = mk(32'hFFF00093, 64'h1000, 64'hFFFFFFFF, 6'd31, `TYPE_I, 6'b000100);
      v32[1]  = mk(32'h00000000, 64'h1004, 64'h0,        6'd0,  `TYPE_I, 6'b000001);
      v32[2]  = mk(32'hFE000EE3, 64'h1008, 64'hFFFFFFFC, 6'd0,  `TYPE_B, 6'b000010);
      v32[3]  = mk(32'h0000001B, 64'h100C, 64'h0,        6'd0,  `TYPE_I, 6'b000001);
      v32[4]  = mk(32'h123452B7, 64'h1010, 64'h12345000, 6'd3,  `TYPE_U, 6'b000100);
      v32[5]  = mk(32'h800000B7, 64'h1014, 64'h80000000, 6'd0,  `TYPE_U, 6'b000100);
      v32[6]  = mk(32'h0020A423, 64'h1018, 64'h8,        6'd2,  `TYPE_S, 6'b001010);
      v32[7]  = mk(32'hFE20AE23, 64'h101C, 64'hFFFFFFFC, 6'd2,  `TYPE_S, 6'b001010);
      v32[8]  = mk(32'h002081B3, 64'h1020, 64'h0,        6'd2,  `TYPE_R, 6'b100100);
      v32[9]  = mk(32'hFF812203, 64'h1024, 64'hFFFFFFF8, 6'd24, `TYPE_I, 6'b010110);
      v32[10] = mk(32'h001000EF, 64'h1028, 64'h800,      6'd1,  `TYPE_J, 6'b000110);
      v32[11] = mk(32'h00008067, 64'h102C, 64'h0,        6'd0,  `TYPE_I, 6'b000110);
      v32[12] = mk(32'h00000073, 64'h1030, 64'h0,        6'd0,  `TYPE_I, 6'b000000);
      v32[13] = mk(32'hFFF00091, 64'h1034, 64'h0,        6'd31, `TYPE_I, 6'b000001);
      v32[14] = mk(32'hFFFFF117, 64'h1038, 64'hFFFFF000, 6'd31, `TYPE_U, 6'b000100);
      v32[15] = mk(32'h0FF0000F, 64'h103C, 64'hFF,       6'd31, `TYPE_I, 6'b000000);

      v64[0] = mk(32'h02109093, 64'h8000_0000_0000_0000, 64'd33,                  6'd33, `TYPE_I, 6'b000100);
      v64[1] = mk(32'h0000001B, 64'h8000_0000_0000_0004, 64'h0,                   6'd0,  `TYPE_I, 6'b000100);
      v64[2] = mk(32'h800000B7, 64'h8000_0000_0000_0008, 64'hFFFF_FFFF_8000_0000, 6'd0,  `TYPE_U, 6'b000100);
      v64[3] = mk(32'hFFF00093, 64'h8000_0000_0000_000C, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, `TYPE_I, 6'b000100);
      v64[4] = mk(32'h002081BB, 64'h8000_0000_0000_0010, 64'h0,                   6'd2,  `TYPE_R, 6'b100100);
      v64[5] = mk(32'hFE000EE3, 64'h8000_0000_0000_0014, 64'hFFFF_FFFF_FFFF_FFFC, 6'd32, `TYPE_B, 6'b000010);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = '0; b_in_pc = '0; b_out_ready = 1'b1;

      // Reset state
      cycles(2);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // One-cycle latency for addi x1,x0,-1
      out_ready = 1'b1;
      send(1'b0, v32[0]);
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // Back-to-back stream: one instruction per cycle
      c0 = cyc;
      for (int i = 1; i < 16; i++) send(1'b0, v32[i]);
      chk("throughput_cycles", 64'(cyc - c0), 64'd15);
      cycles(3);

      // Backpressure: A in main, B in skid, C held
      out_ready = 1'b0;
      xa = mk(32'h00100113, 64'h2000, 64'h1, 6'd1, `TYPE_I, 6'b000100);
      xb = mk(32'h002081B3, 64'h2004, 64'h0, 6'd2, `TYPE_R, 6'b100100);
      xc = mk(32'h0020A423, 64'h2008, 64'h8, 6'd2, `TYPE_S, 6'b001010);
      send(1'b0, xa);
      send(1'b0, xb);
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_main_pc", 64'(out_pc), 64'h2000);
      fork
         send(1'b0, xc);
         begin
            @(negedge clk);
            chk("bp_hold_pc", 64'(out_pc), 64'h2000);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      cycles(4);
      chk("bp_drained_valid", 64'(out_valid), 64'd0);

      // Flush with main and skid full while an instruction is offered
      out_ready = 1'b0;
      send(1'b0, v32[4]);
      send(1'b0, v32[5]);
      xx = mk(32'h00500293, 64'h3000, 64'h5, 6'd5, `TYPE_I, 6'b000100);
      in_valid = 1'b1; in_inst = xx.inst; in_pc = xx.pc[31:0];
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("flush_full_out_valid", 64'(out_valid), 64'd0);
      chk("flush_full_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Flush with only main full: the offered instruction is accepted-eligible but must be dropped
      send(1'b0, v32[6]);
      in_valid = 1'b1; in_inst = xx.inst; in_pc = xx.pc[31:0];
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q32.delete();
      out_ready = 1'b1;
      cycles(3);
      @(negedge clk);
      chk("flush_drop_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      send(1'b0, v32[8]);
      cycles(2);

      // Reset while main and skid are full
      out_ready = 1'b0;
      send(1'b0, v32[9]);
      send(1'b0, v32[10]);
      @(negedge clk);
      chk("pre_rst_skid_full", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_pc", 64'(out_pc), 64'd0);
      chk("midrst_out_imm", 64'(out_imm), 64'd0);
      chk("midrst_out_fields", 64'({out_opcode, out_rd, out_funct7, out_opcode_type, out_is_writeback, out_use_adder, out_is_load}), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_in_ready_after", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      cycles(3);
      @(negedge clk);
      chk("midrst_nothing_emerges", 64'(out_valid), 64'd0);
      @(posedge clk); #1;

      // 64-bit instance vectors
      for (int i = 0; i < 6; i++) send(1'b1, v64[i]);

      // Drain both scoreboards (bounded)
      for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) @(posedge clk);
      #1;
      chk("q32_empty", 64'(q32.size()), 64'd0);
      chk("q64_empty", 64'(q64.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter SHAMT_W, default derived: 5 when XLEN=32, 6 when XLEN=64.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be as follows; out_* fields are registered.
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill all held instructions (taken jump/branch).
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  pc of decoded instruction.
- out_opcode  out  7  inst[6:0].
- out_rd, out_rs, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_imm  out  XLEN  sign-extended immediate.
- out_shamt  out  SHAMT_W  inst[20+SHAMT_W-1:20].
- out_opcode_type  out  3  `TYPE_R/I/S/B/U/J encoding.
- out_is_r_type, out_is_load, out_is_store, out_is_writeback, out_use_adder  out  1 each  control flags.
- out_illegal  out  1  instruction not decodable.

Function
REQ-005 Transfer on a port SHALL occur when valid and ready are both high in the same cycle.
REQ-006 The stage SHALL hold a main register and one skid register; latency in_valid fire to out_valid = 1 cycle; throughput 1 instruction/cycle under no backpressure.
REQ-007 in_ready SHALL be registered: in_ready = ~skid_full, and 0 while rst is high.
REQ-008 Accept with main empty, or main firing this cycle and skid empty: the decoded instruction SHALL load into main.
REQ-009 Accept with main full and not firing: the decoded instruction SHALL load into skid; in_ready drops next cycle.
REQ-010 Main firing with skid full: skid SHALL move to main and skid empties; in_ready rises next cycle.
REQ-011 Instruction order SHALL be preserved; no instruction is dropped or duplicated except by flush/reset.
REQ-012 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 Flush SHALL clear main and skid valid next cycle, drop any in_valid offered that cycle, and make in_ready=1 next cycle; flush has priority over every simultaneous accept or move.
REQ-014 Opcode classification {is_load,is_store,is_writeback,use_adder,type}:
- LUI, AUIPC: 0,0,1,0,U.
- OP: 0,0,1,0,R.
- OP_IMM: 0,0,1,0,I.
- JAL: 0,0,1,1,J.
- JALR: 0,0,1,1,I.
- BRANCH: 0,0,0,1,B.
- LOAD: 1,0,1,1,I.
- STORE: 0,1,0,1,S.
- MISC_MEM, SYSTEM: 0,0,0,0,I.
- When XLEN=64, OP_IMM_32 (0011011) SHALL be 0,0,1,0,I and OP_32 (0111011) SHALL be 0,0,1,0,R.
REQ-015 Immediates per RV spec for I/S/B/U/J, sign-extended from inst[31] to XLEN; U immediate SHALL be {inst[31:12],12'b0} sign-extended to XLEN; R type SHALL give imm 0.
REQ-016 out_illegal=1 when inst[1:0]!=2'b11, the opcode is not listed in REQ-014, or the opcode is OP_IMM_32/OP_32 with XLEN=32; then all four flags are 0, type I, imm 0, and the instruction still flows through the stage.
REQ-017 out_is_r_type SHALL equal (out_opcode_type == `TYPE_R).

Reset
REQ-018 On rst, the block SHALL clear main and skid valid and drive out_valid=0, in_ready=0 and all out_* data fields to 0; in_ready=1 the cycle after rst deasserts.
REQ-019 Reset mid-operation SHALL discard held instructions; nothing emerges afterwards until new input is accepted.

Verification
REQ-020 XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, type I, writeback=1, illegal=0.
REQ-021 Backpressure: A,B,C offered on consecutive cycles with out_ready=0 -> A in main, B in skid, in_ready=0, C held upstream; then out_ready=1 -> A,B,C emerge in order, one per cycle.
REQ-022 Flush with main and skid full and in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the offered instruction never appears at the output.
REQ-023 XLEN=64, in_inst=0x02109093 (slli x1,x1,33) -> shamt=33, illegal=0; XLEN=32, in_inst=0x0000001B -> illegal=1, writeback=0.
REQ-024 Rst asserted for 1 cycle while out_valid=1 and skid full -> out_valid=0 and all data fields 0; in_ready=1 the cycle after rst deasserts.
REQ-025 in_inst=0x00000000 -> illegal=1; in_inst=0xFE000EE3 (beq, offset -4) -> type B, imm=-4, use_adder=1, writeback=0.
